// File: rtl/sa_pkg.sv
// Shared sizing and FSM state encoding for the systolic-array drain collector.
package sa_pkg;

    localparam int ROW_NUM  = 32;
    localparam int COL_NUM  = 32;
    localparam int PIX88_W  = 24;
    localparam int PIX18_W  = 16;
    localparam int SA_OUT_W = PIX18_W * 2 * 2 * COL_NUM;
    localparam int LANES    = SA_OUT_W / PIX18_W;
    localparam int LANES88  = LANES / 2;
    localparam int SHIFT_W  = 5;
    localparam int CH_W     = $clog2(ROW_NUM);

    // Drain sequencer states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PRIME  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

endpackage

// File: rtl/sa_lane_quant.sv
// One lane of requantisation: rounding arithmetic right shift, then clamp to int8.
module sa_lane_quant
    import sa_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic [IN_W-1:0]    i_lane,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [7:0]         o_q
);

    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(127);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W+1)'(-128);

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_round;
    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shr;

    // One extra bit absorbs the half-LSB rounding add; shifts of IN_W or more always round to zero.
    always_comb begin
        w_ext   = {i_lane[IN_W-1], i_lane};
        w_round = '0;
        if (i_shift != '0) begin
            w_round = (IN_W+1)'(1) << (i_shift - SHIFT_W'(1));
        end
        w_sum = w_ext + w_round;
        w_shr = w_sum >>> i_shift;
        if (32'(i_shift) >= IN_W) begin
            w_shr = '0;
        end
        if (w_shr > SAT_MAX) begin
            o_q = 8'h7F;
        end else if (w_shr < SAT_MIN) begin
            o_q = 8'h80;
        end else begin
            o_q = w_shr[7:0];
        end
    end

endmodule

// File: rtl/sa_drain_collector.sv
// Drains ROW_NUM channel words from the systolic array, requantises every lane to int8
// and streams one channel per beat over valid/ready.
module sa_drain_collector
    import sa_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic [SA_OUT_W-1:0]   sa_out,
    output logic                  channel_out_reset,
    output logic                  channel_out_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LANES*8-1:0]    m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    logic [1:0]           r_state;
    logic                 r_mode;
    logic [SHIFT_W-1:0]   r_shift;
    logic [CH_W-1:0]      r_ch_cnt;
    logic                 r_m_valid;
    logic [LANES*8-1:0]   r_m_data;
    logic                 r_m_last;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_load;
    logic                 w_ch_last;
    logic [LANES*8-1:0]   w_q18;
    logic [LANES*8-1:0]   w_q88;
    logic [LANES*8-1:0]   w_quant;

    // 1x8 packing: every 16-bit slice of the array word is its own lane
    for (genvar k = 0; k < LANES; k++) begin : g_q18
        sa_lane_quant #(.IN_W(PIX18_W)) u_quant (
            .i_lane  (sa_out[k*PIX18_W +: PIX18_W]),
            .i_shift (r_shift),
            .o_q     (w_q18[k*8 +: 8])
        );
    end

    // 8x8 packing: only the low 64 lanes of 24 bits carry data, the upper output lanes stay zero
    for (genvar k = 0; k < LANES88; k++) begin : g_q88
        sa_lane_quant #(.IN_W(PIX88_W)) u_quant (
            .i_lane  (sa_out[k*PIX88_W +: PIX88_W]),
            .i_shift (r_shift),
            .o_q     (w_q88[k*8 +: 8])
        );
    end
    assign w_q88[LANES*8-1:LANES88*8] = '0;

    assign w_quant   = r_mode ? w_q18 : w_q88;
    assign w_load    = !r_m_valid || m_ready;
    assign w_ch_last = (r_ch_cnt == CH_W'(ROW_NUM - 1));

    // Array counter control: park at idle on reset/start/final handoff, step once per captured channel
    always_comb begin
        channel_out_reset = reset
                          || ((r_state == IDLE)  && start)
                          || ((r_state == DRAIN) && r_m_valid && m_ready);
        channel_out_en    = !reset
                          && ((r_state == PRIME)
                           || ((r_state == STREAM) && w_load && !w_ch_last));
    end

    // Sequencer and output beat register; the output register doubles as the skid so sa_out is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mode    <= 1'b0;
            r_shift   <= '0;
            r_ch_cnt  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_shift <= shift;
                        r_busy  <= 1'b1;
                        r_state <= PRIME;
                    end
                end
                PRIME: begin
                    r_ch_cnt <= '0;
                    r_state  <= STREAM;
                end
                STREAM: begin
                    if (w_load) begin
                        r_m_data  <= w_quant;
                        r_m_valid <= 1'b1;
                        r_m_last  <= w_ch_last;
                        if (w_ch_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CH_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (r_m_valid && m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sa_drain_collector.sv
// Bench for sa_drain_collector: behavioural array model, lane-quant reference and drain scoreboard.
module tb_sa_drain_collector;
    import sa_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 mode;
    logic [SHIFT_W-1:0]   shift;
    logic [SA_OUT_W-1:0]  sa_out;
    logic                 channel_out_reset;
    logic                 channel_out_en;
    logic                 m_valid;
    logic                 m_ready;
    logic [LANES*8-1:0]   m_data;
    logic                 m_last;
    logic                 busy;
    logic                 done;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [SA_OUT_W-1:0]  chanWord [ROW_NUM];
    logic [LANES*8-1:0]   firstBeat;
    int                   arrCnt = -1;

    typedef struct {
        logic        md;
        logic [4:0]  sh;
        logic [23:0] laneVal;
        logic [7:0]  expQ;
    } qvec_t;
    qvec_t vecs [10];

    sa_drain_collector dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mode              (mode),
        .shift             (shift),
        .sa_out            (sa_out),
        .channel_out_reset (channel_out_reset),
        .channel_out_en    (channel_out_en),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_last            (m_last),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Array side: channel counter parks at -1, steps on enable, word appears the cycle after
    always @(posedge clk) begin
        if (channel_out_reset) arrCnt <= -1;
        else if (channel_out_en) arrCnt <= arrCnt + 1;
    end
    assign sa_out = (arrCnt >= 0 && arrCnt < ROW_NUM) ? chanWord[arrCnt] : '0;

    function automatic int quantLane(input longint v, input int sh);
        longint q;
        if (sh == 0) q = v;
        else q = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic logic [LANES*8-1:0] expectBeat(input logic [SA_OUT_W-1:0] w,
                                                      input logic md, input int sh);
        logic [LANES*8-1:0] r;
        logic signed [23:0] s24;
        logic signed [15:0] s16;
        longint v;
        int q;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (md == 1'b0) begin
                if (k < 64) begin
                    s24 = w[k*24 +: 24];
                    v = s24;
                    q = quantLane(v, sh);
                    r[k*8 +: 8] = 8'(q);
                end
            end else begin
                s16 = w[k*16 +: 16];
                v = s16;
                q = quantLane(v, sh);
                r[k*8 +: 8] = 8'(q);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkBeat(input string name, input logic [LANES*8-1:0] act,
                             input logic [LANES*8-1:0] exp);
        int bad;
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            bad = 0;
            for (int k = LANES - 1; k >= 0; k--) if (act[k*8 +: 8] !== exp[k*8 +: 8]) bad = k;
            $display("[TB] FAIL %s: lane %0d got %0d expected %0d", name, bad,
                     $signed(act[bad*8 +: 8]), $signed(exp[bad*8 +: 8]));
        end
    endtask

    task automatic fillRandom();
        for (int c = 0; c < ROW_NUM; c++)
            for (int j = 0; j < SA_OUT_W / 32; j++) chanWord[c][j*32 +: 32] = $urandom;
    endtask

    task automatic fillPattern();
        for (int c = 0; c < ROW_NUM; c++) begin
            chanWord[c] = '0;
            for (int k = 0; k < LANES; k++) chanWord[c][k*16 +: 16] = 16'(c*4 + k - 64);
        end
    endtask

    task automatic fillConst(input logic md, input logic [23:0] val);
        fillRandom();
        for (int c = 0; c < ROW_NUM; c++) begin
            if (md == 1'b0) for (int k = 0; k < 64; k++) chanWord[c][k*24 +: 24] = val;
            else for (int k = 0; k < LANES; k++) chanWord[c][k*16 +: 16] = val[15:0];
        end
    endtask

    // readyMode: 0 always ready, 1 random, 2 five-cycle stall on beat 3
    task automatic applyStimulus(input logic md, input logic [4:0] sh, input int readyMode,
                                 input bit pokeStart, input bit checkLat);
        int cyc, beats, firstValid, lastAcc, stallCnt, corCount;
        bit doneSeen, prevHold, prevLast;
        logic [LANES*8-1:0] prevData;
        beats = 0; firstValid = -1; lastAcc = -1; stallCnt = 0; corCount = 0;
        doneSeen = 0; prevHold = 0; prevLast = 0; prevData = '0;
        @(posedge clk); #1;
        start = 1'b1; mode = md; shift = sh; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!doneSeen && cyc < 300) begin
            case (readyMode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (m_valid && beats == 3 && stallCnt < 5) begin
                        m_ready = 1'b0;
                        stallCnt++;
                    end else m_ready = 1'b1;
                end
            endcase
            if (pokeStart && cyc == 10) begin
                start = 1'b1; mode = ~md; shift = sh + 5'd3;
            end else begin
                start = 1'b0; mode = md; shift = sh;
            end
            #1;
            if (pokeStart && cyc == 10) checkOutput("busy_during_drain", busy, 1);
            if (prevHold) begin
                checkOutput("hold_valid", m_valid, 1);
                checkBeat("hold_data", m_data, prevData);
                checkOutput("hold_last", m_last, prevLast);
            end
            if (m_valid && !m_ready) checkOutput("en_while_stalled", channel_out_en, 0);
            if (channel_out_reset) corCount++;
            if (m_valid && firstValid < 0) firstValid = cyc;
            if (m_valid && m_ready) begin
                if (beats < ROW_NUM) begin
                    checkBeat("beat_data", m_data, expectBeat(chanWord[beats], md, int'(sh)));
                    checkOutput("beat_last", m_last, (beats == ROW_NUM - 1));
                    if (beats == 0) firstBeat = m_data;
                end else checkOutput("extra_beat", beats, ROW_NUM - 1);
                beats++;
                lastAcc = cyc;
            end
            prevHold = m_valid && !m_ready;
            prevData = m_data;
            prevLast = m_last;
            if (done) begin
                doneSeen = 1;
                checkOutput("done_timing", cyc, lastAcc + 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; mode = md; shift = sh;
        checkOutput("drain_completed", doneSeen, 1);
        checkOutput("beat_count", beats, ROW_NUM);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("chan_reset_pulses", corCount, 1);
        if (checkLat) checkOutput("first_valid_latency", firstValid, 3);
    endtask

    task automatic checkReset();
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_chan_en", channel_out_en, 0);
        checkOutput("rst_chan_reset", channel_out_reset, 1);
        checkBeat("rst_m_data", m_data, '0);
    endtask

    initial begin
        int seen;
        bit aborted;
        logic rmd;
        logic [4:0] rsh;

        vecs[0] = '{1'b0, 5'd4,  24'h000018, 8'h02};
        vecs[1] = '{1'b0, 5'd4,  24'hFFFFE8, 8'hFF};
        vecs[2] = '{1'b0, 5'd0,  24'h7FFFFF, 8'h7F};
        vecs[3] = '{1'b0, 5'd0,  24'h800000, 8'h80};
        vecs[4] = '{1'b1, 5'd8,  24'h007FFF, 8'h7F};
        vecs[5] = '{1'b1, 5'd0,  24'h00FFFB, 8'hFB};
        vecs[6] = '{1'b1, 5'd3,  24'h00FFEC, 8'hFE};
        vecs[7] = '{1'b0, 5'd31, 24'h7FFFFF, 8'h00};
        vecs[8] = '{1'b1, 5'd1,  24'h000003, 8'h02};
        vecs[9] = '{1'b0, 5'd2,  24'hFFFFFA, 8'hFF};

        reset = 1'b1; start = 1'b0; mode = 1'b0; shift = '0; m_ready = 1'b0;
        fillPattern();
        repeat (3) @(posedge clk);
        #1;
        checkReset();
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] mode 1 ramp pattern, continuous ready");
        applyStimulus(1'b1, 5'd0, 0, 1'b0, 1'b1);

        $display("[TB] quantisation vector table");
        for (int i = 0; i < 10; i++) begin
            fillConst(vecs[i].md, vecs[i].laneVal);
            applyStimulus(vecs[i].md, vecs[i].sh, 0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_lane0", i), $signed(firstBeat[7:0]), $signed(vecs[i].expQ));
            checkOutput($sformatf("vec%0d_lane100", i), $signed(firstBeat[100*8 +: 8]),
                        vecs[i].md ? $signed(vecs[i].expQ) : 0);
        end

        $display("[TB] backpressure stall on beat 3");
        fillRandom();
        applyStimulus(1'b0, 5'd3, 2, 1'b0, 1'b1);

        $display("[TB] randomised drains");
        for (int r = 0; r < 4; r++) begin
            fillRandom();
            rmd = 1'($urandom_range(0, 1));
            rsh = 5'($urandom_range(0, 31));
            applyStimulus(rmd, rsh, 1, (r == 0), 1'b0);
        end

        $display("[TB] reset during beat 10");
        fillRandom();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; shift = 5'd2; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0; aborted = 0;
        for (int i = 0; i < 100 && !aborted; i++) begin
            if (m_valid) begin
                if (seen == 10) begin
                    reset = 1'b1;
                    aborted = 1;
                end else seen++;
            end
            if (!aborted) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("abort_reached_beat10", aborted, 1);
        @(posedge clk); #1;
        checkOutput("abort_m_valid", m_valid, 0);
        checkOutput("abort_chan_reset", channel_out_reset, 1);
        checkOutput("abort_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_chan_reset", channel_out_reset, 0);
        checkOutput("idle_m_valid", m_valid, 0);

        $display("[TB] fresh drain after abort, then toggled mode");
        fillPattern();
        applyStimulus(1'b1, 5'd0, 0, 1'b0, 1'b1);
        fillRandom();
        applyStimulus(1'b0, 5'd6, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
